// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master serializer for 24-bit stereo pairs.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_left/s_right
// sample handshake; i2s_bclk/i2s_lrclk/i2s_sdata toward the DAC;
// underrun pulses when a frame goes out with no sample available.
module i2s_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              underrun
);

  localparam int FR_W = 2 * SLOT_W;
  localparam int CW   = $clog2(2 * BCLK_DIV);
  localparam int KW   = $clog2(FR_W);
  localparam int PAD  = SLOT_W - 1 - DATA_W;

  localparam logic [CW-1:0] C_LAST = CW'(2 * BCLK_DIV - 1);
  localparam logic [CW-1:0] C_HI   = CW'(BCLK_DIV);
  localparam logic [KW-1:0] K_LAST = KW'(FR_W - 1);
  localparam logic [KW-1:0] K_R    = KW'(SLOT_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [CW-1:0]     cnt, cnt_n;
  logic [KW-1:0]     k, k_n;
  logic [FR_W-1:0]   sh, load_word;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic              xfer, per_end, boundary;

  // Each slot: one leading zero (I2S delay), sample MSB first, zero pad.
  function automatic logic [FR_W-1:0] frame(
    input logic [DATA_W-1:0] l,
    input logic [DATA_W-1:0] r
  );
    logic [SLOT_W-1:0] lw, rw;
    lw = SLOT_W'(l) << PAD;
    rw = SLOT_W'(r) << PAD;
    return {lw, rw};
  endfunction

  always_comb begin
    state_n   = state;
    xfer      = s_valid && s_ready;
    per_end   = (cnt == C_LAST);
    boundary  = (state == RUN) && per_end && (k == K_LAST);
    cnt_n     = per_end ? '0 : cnt + CW'(1);
    k_n       = k;
    load_word = '0;
    if (per_end)
      k_n = (k == K_LAST) ? '0 : k + KW'(1);
    // A full holding register wins; otherwise take the live inputs.
    if (!s_ready)
      load_word = frame(hold_l, hold_r);
    else if (s_valid)
      load_word = frame(s_left, s_right);
    unique case (state)
      IDLE: if (xfer) state_n = RUN;
      RUN:  state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      k         <= '0;
      sh        <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      s_ready   <= 1'b1;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (state == IDLE) begin
        if (xfer) begin
          cnt       <= '0;
          k         <= '0;
          sh        <= load_word << 1;
          i2s_sdata <= load_word[FR_W-1];
        end
      end else begin
        cnt       <= cnt_n;
        k         <= k_n;
        i2s_bclk  <= (cnt_n >= C_HI);
        i2s_lrclk <= (k_n >= K_R);
        if (xfer && !boundary) begin
          hold_l  <= s_left;
          hold_r  <= s_right;
          s_ready <= 1'b0;
        end
        if (boundary) begin
          sh        <= load_word << 1;
          i2s_sdata <= load_word[FR_W-1];
          s_ready   <= 1'b1;
          if (s_ready && !s_valid)
            underrun <= 1'b1;
        end else if (per_end) begin
          sh        <= sh << 1;
          i2s_sdata <= sh[FR_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with default parameters.
// Captures whole frames at BCLK rising edges and checks framing/handshake.
module tb_i2s_tx;

  logic        clk = 0;
  logic        rst = 1;
  logic        s_valid = 0;
  logic        s_ready;
  logic [23:0] s_left = '0;
  logic [23:0] s_right = '0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

  int total = 0;
  int bad = 0;

  i2s_tx dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .i2s_bclk (i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] efr(input logic [23:0] l,
                                      input logic [23:0] r);
    logic [63:0] v;
    v = '0;
    for (int p = 0; p < 64; p++) begin
      if (p >= 1 && p <= 24)       v[p] = l[24-p];
      else if (p >= 33 && p <= 56) v[p] = r[24-(p-32)];
    end
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_bclk"}, 64'(i2s_bclk), 64'd0);
    chk({tag, "_lr"}, 64'(i2s_lrclk), 64'd0);
    chk({tag, "_sd"}, 64'(i2s_sdata), 64'd0);
    chk({tag, "_rdy"}, 64'(s_ready), 64'd1);
    chk({tag, "_und"}, 64'(underrun), 64'd0);
  endtask

  // Called #1 after the edge that makes period 0, cycle 0 visible.
  task automatic cap(input string tag,
                     input logic [23:0] l, input logic [23:0] r,
                     input bit bnd, input logic [23:0] bl,
                     input logic [23:0] br,
                     input int exp_low, input int exp_und,
                     output logic [63:0] sd_out);
    logic [63:0] lr_v, sd_v;
    logic        lr0, sd0;
    int bad_bclk, glitch, low, und, und_at;
    lr_v = '0; sd_v = '0; lr0 = 0; sd0 = 0;
    bad_bclk = 0; glitch = 0; low = 0; und = 0; und_at = -1;
    for (int p = 0; p < 64; p++) begin
      for (int c = 0; c < 8; c++) begin
        if (i2s_bclk !== (c >= 4)) bad_bclk++;
        if (c == 0) begin
          lr0 = i2s_lrclk;
          sd0 = i2s_sdata;
        end else if (i2s_lrclk !== lr0 || i2s_sdata !== sd0) begin
          glitch++;
        end
        if (c == 4) begin
          lr_v[p] = i2s_lrclk;
          sd_v[p] = i2s_sdata;
        end
        if (!s_ready) low++;
        if (underrun) begin
          und++;
          if (und_at < 0) und_at = p * 8 + c;
        end
        if (bnd && p == 63 && c == 7) begin
          s_valid = 1;
          s_left  = bl;
          s_right = br;
        end
        step();
      end
    end
    if (bnd) s_valid = 0;
    chk({tag, "_bclk"}, 64'(bad_bclk), 64'd0);
    chk({tag, "_stable"}, 64'(glitch), 64'd0);
    chk({tag, "_lrclk"}, lr_v, 64'hFFFF_FFFF_0000_0000);
    chk({tag, "_sdata"}, sd_v, efr(l, r));
    chk({tag, "_rdylow"}, 64'(low), 64'(exp_low));
    chk({tag, "_und"}, 64'(und), 64'(exp_und));
    if (exp_und > 0) chk({tag, "_und_at"}, 64'(und_at), 64'd0);
    sd_out = sd_v;
  endtask

  logic [23:0] pl [4];
  logic [23:0] pr [4];
  logic [63:0] sd;
  int          guard;

  initial begin
    pl[0] = 24'h123456; pr[0] = 24'hABCDEF;
    pl[1] = 24'hFFFFFF; pr[1] = 24'h000001;
    pl[2] = 24'h5A5A5A; pr[2] = 24'hA5A5A5;
    pl[3] = 24'h800000; pr[3] = 24'h7FFFFF;

    // 1: reset with s_valid high for 3 cycles
    s_valid = 1;
    s_left  = 24'h800001;
    s_right = 24'h7FFFFE;
    rst     = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_rst_vals($sformatf("rst%0d", i));
    end
    rst = 0;
    step();
    s_valid = 0;

    // 2: single frame; exact latency checked by framing
    cap("single", 24'h800001, 24'h7FFFFE, 0, '0, '0, 0, 0, sd);
    chk("single_p1", 64'(sd[1]), 64'd1);
    chk("single_p24", 64'(sd[24]), 64'd1);
    chk("single_p33", 64'(sd[33]), 64'd0);
    chk("single_p56", 64'(sd[56]), 64'd0);
    chk("single_ones", 64'($countones(sd)), 64'd24);
    chk("single_und_next", 64'(underrun), 64'd1);

    rst = 1;
    step();
    rst = 0;
    chk_rst_vals("rst_b");

    // 3: streaming four pairs with s_valid held high
    s_valid = 1;
    s_left  = pl[0];
    s_right = pr[0];
    step();
    fork
      begin
        guard = 0;
        for (int i = 1; i < 4; i++) begin
          s_left  = pl[i];
          s_right = pr[i];
          while (!s_ready && guard < 3000) begin
            step();
            guard++;
          end
          step();
        end
        s_valid = 0;
        chk("stream_guard", 64'(guard < 3000), 64'd1);
      end
      begin
        cap("str0", pl[0], pr[0], 0, '0, '0, 511, 0, sd);
        cap("str1", pl[1], pr[1], 0, '0, '0, 511, 0, sd);
        cap("str2", pl[2], pr[2], 0, '0, '0, 511, 0, sd);
        cap("str3", pl[3], pr[3], 0, '0, '0, 0, 0, sd);
      end
    join

    // 4: underrun frame, then 5: transfer only in the boundary cycle
    cap("undr", '0, '0, 0, '0, '0, 0, 1, sd);
    cap("bnd0", '0, '0, 1, 24'hC0FFEE, 24'h0BEEF1, 0, 1, sd);
    // boundary-loaded pair is the next frame; s_valid is raised for cycle 0
    s_valid = 1;
    s_left  = 24'h111111;
    s_right = 24'h222222;
    step();
    s_valid = 0;
    chk("bnd_hold_rdy", 64'(s_ready), 64'd0);
    // rewind not possible; the 1-cycle step above is cycle 0 of frame 7
    for (int i = 0; i < 40 * 8 + 1; i++) begin
      if (i == 0) begin
        chk("bnd_und_none", 64'(underrun), 64'd0);
        chk("bnd_p0_lr", 64'(i2s_lrclk), 64'd0);
      end
      if (i == 8 + 4)
        chk("bnd_msb", 64'(i2s_sdata), 64'(1'b1));
      if (i == 8 * 24 + 4)
        chk("bnd_lsb", 64'(i2s_sdata), 64'(1'b0));
      step();
    end
    // 6: reset during period 40 while holding is full
    chk("mid_lr_before", 64'(i2s_lrclk), 64'd1);
    rst = 1;
    step();
    rst = 0;
    chk_rst_vals("mid");
    s_valid = 1;
    s_left  = 24'h00F00F;
    s_right = 24'hFEDCBA;
    step();
    s_valid = 0;
    cap("restart", 24'h00F00F, 24'hFEDCBA, 0, '0, '0, 0, 0, sd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
